// File: rtl/cc_pkg.sv
// Shared helpers for the multi-channel clock-crossing counter: Gray
// conversion, the rule that sizes the Gray-crossed part of each counter,
// and the classification of upper-bit extension moves.
package cc_pkg;

    // Widest value the Gray helpers handle; counters are at most this wide.
    localparam int MAX_W = 32;

    // How the destination-side upper bits move for one sample.
    typedef enum logic [1:0] {
        EXT_HOLD = 2'd0,
        EXT_UP   = 2'd1,
        EXT_DOWN = 2'd2
    } ext_move_e;

    // Number of low bits crossed in Gray code: never wider than the
    // counter, never narrower than 3 so the top-two-bit wrap detector
    // always has a quadrant in between.
    function automatic int gray_width(input int gray_bits, input int width);
        int w;
        w = gray_bits;
        if (w > width) begin
            w = width;
        end
        if (w < 3) begin
            w = 3;
        end
        return w;
    endfunction

    // Binary to reflected Gray code.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the top bit).
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A wrap of the Gray-crossed part shows up as its top two bits jumping
    // between the 11 and 00 quadrants; anything else leaves the upper bits.
    function automatic ext_move_e ext_move(input logic [1:0] prev_top,
                                           input logic [1:0] next_top,
                                           input logic       allow_down);
        ext_move_e m;
        m = EXT_HOLD;
        if (prev_top == 2'b11 && next_top == 2'b00) begin
            m = EXT_UP;
        end else if (allow_down && prev_top == 2'b00 && next_top == 2'b11) begin
            m = EXT_DOWN;
        end
        return m;
    endfunction

endpackage

// File: rtl/cc_counter_mc_chan.sv
// One counter channel: source-domain up/down counter, registered Gray
// copy of its low bits, per-bit synchronizers into the destination
// domain, Gray decode and upper-bit extension tracking.
module cc_counter_mc_chan
    import cc_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               GRAY_W      = 16,
    parameter int               SYNC_STAGES = 2,
    parameter int               UPDOWN      = 0,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_inc,
    input  logic             in_dec,
    input  logic             out_clk,
    input  logic             out_rst,
    output logic [WIDTH-1:0] in_count,
    output logic [WIDTH-1:0] out_count
);

    localparam logic [GRAY_W-1:0] GRAY_INIT =
        GRAY_W'(bin2gray(MAX_W'(INIT[GRAY_W-1:0])));

    logic              dec_en;
    logic [WIDTH-1:0]  cnt_d;
    logic [WIDTH-1:0]  cnt_q;
    logic [GRAY_W-1:0] gray_d;
    logic [GRAY_W-1:0] gray_q;
    logic [GRAY_W-1:0] gray_sync;
    logic [GRAY_W-1:0] low_bin;
    logic [WIDTH-1:0]  out_cnt_d;
    logic [WIDTH-1:0]  out_cnt_q;

    assign dec_en = (UPDOWN != 0) ? in_dec : 1'b0;

    // Next count and the Gray image of the current count's low bits.
    always_comb begin
        cnt_d  = cnt_q;
        gray_d = GRAY_W'(bin2gray(MAX_W'(cnt_q[GRAY_W-1:0])));
        if (in_rst) begin
            cnt_d  = INIT;
            gray_d = GRAY_INIT;
        end else if (in_inc && !dec_en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_en && !in_inc) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Source-domain count and Gray register; only one Gray bit moves per cycle.
    always_ff @(posedge in_clk) begin
        cnt_q  <= cnt_d;
        gray_q <= gray_d;
    end

    assign in_count = cnt_q;

    for (genvar i = 0; i < GRAY_W; i++) begin : g_sync
        cc_sync_bit #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL (GRAY_INIT[i])
        ) u_sync (
            .clk (out_clk),
            .rst (out_rst),
            .d   (gray_q[i]),
            .q   (gray_sync[i])
        );
    end

    assign low_bin = GRAY_W'(gray2bin(MAX_W'(gray_sync)));

    if (GRAY_W < WIDTH) begin : g_ext
        localparam int EXT_W = WIDTH - GRAY_W;

        ext_move_e        move;
        logic [EXT_W-1:0] ext_d;

        // Rebuild the upper bits from wraps of the crossed low part.
        always_comb begin
            move  = ext_move(out_cnt_q[GRAY_W-1 -: 2], low_bin[GRAY_W-1 -: 2],
                             UPDOWN != 0);
            ext_d = out_cnt_q[WIDTH-1:GRAY_W];
            case (move)
                EXT_UP:   ext_d = ext_d + EXT_W'(1);
                EXT_DOWN: ext_d = ext_d - EXT_W'(1);
                default:  ext_d = out_cnt_q[WIDTH-1:GRAY_W];
            endcase
            out_cnt_d = {ext_d, low_bin};
        end
    end else begin : g_noext
        // Whole counter is crossed, so the decode is the full value.
        always_comb begin
            out_cnt_d = low_bin;
        end
    end

    // Destination-domain reconstructed count.
    always_ff @(posedge out_clk or posedge out_rst) begin
        if (out_rst) begin
            out_cnt_q <= INIT;
        end else begin
            out_cnt_q <= out_cnt_d;
        end
    end

    assign out_count = out_cnt_q;

endmodule

// File: rtl/cc_sync_bit.sv
// Single-bit multi-flop synchronizer cell with asynchronous active-high
// reset to a selectable value.
module cc_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    // Shift the incoming bit one stage further down the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops, reset straight to the idle value of the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cc_counter_mc.sv
// Multi-channel event counter counted in in_clk and mirrored into out_clk,
// with a per-channel threshold flag and a coherent all-channel snapshot.
module cc_counter_mc
    import cc_pkg::*;
#(
    parameter int               NCH         = 4,
    parameter int               WIDTH       = 16,
    parameter int               GRAY_BITS   = WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter int               UPDOWN      = 0,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 out_clk,
    input  logic                 out_rst,
    input  logic [NCH-1:0]       in_inc,
    input  logic [NCH-1:0]       in_dec,
    output logic [NCH*WIDTH-1:0] in_counter,
    output logic [NCH*WIDTH-1:0] out_counter,
    input  logic [WIDTH-1:0]     out_thresh,
    output logic [NCH-1:0]       out_thresh_hit,
    input  logic                 out_snap_req,
    output logic                 out_snap_valid,
    output logic [NCH*WIDTH-1:0] out_snap
);

    localparam int GRAY_W = gray_width(GRAY_BITS, WIDTH);

    logic [NCH-1:0]       hit_d;
    logic [NCH-1:0]       hit_q;
    logic [NCH*WIDTH-1:0] snap_d;
    logic [NCH*WIDTH-1:0] snap_q;
    logic                 snap_valid_d;
    logic                 snap_valid_q;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        cc_counter_mc_chan #(
            .WIDTH       (WIDTH),
            .GRAY_W      (GRAY_W),
            .SYNC_STAGES (SYNC_STAGES),
            .UPDOWN      (UPDOWN),
            .INIT        (INIT)
        ) u_chan (
            .in_clk    (in_clk),
            .in_rst    (in_rst),
            .in_inc    (in_inc[c]),
            .in_dec    (in_dec[c]),
            .out_clk   (out_clk),
            .out_rst   (out_rst),
            .in_count  (in_counter[c*WIDTH +: WIDTH]),
            .out_count (out_counter[c*WIDTH +: WIDTH])
        );
    end

    // Compare each registered destination count against the shared threshold.
    always_comb begin
        hit_d = '0;
        for (int c = 0; c < NCH; c++) begin
            hit_d[c] = (out_counter[c*WIDTH +: WIDTH] >= out_thresh);
        end
    end

    // Capture every channel at once on request, otherwise hold the last capture.
    always_comb begin
        snap_d       = out_snap_req ? out_counter : snap_q;
        snap_valid_d = out_snap_req;
    end

    // Threshold flags and snapshot registers in the destination domain.
    always_ff @(posedge out_clk or posedge out_rst) begin
        if (out_rst) begin
            hit_q        <= '0;
            snap_q       <= {NCH{INIT}};
            snap_valid_q <= 1'b0;
        end else begin
            hit_q        <= hit_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign out_thresh_hit = hit_q;
    assign out_snap       = snap_q;
    assign out_snap_valid = snap_valid_q;

endmodule

// File: tb/tb_cc_counter_mc.sv
// Directed self-checking bench for cc_counter_mc with a narrow Gray part
// so the destination-side extension logic is exercised.
module tb_cc_counter_mc;

    localparam int               NCH         = 4;
    localparam int               WIDTH       = 16;
    localparam int               GRAY_BITS   = 4;
    localparam int               SYNC_STAGES = 2;
    localparam int               UPDOWN      = 1;
    localparam logic [WIDTH-1:0] INIT        = '0;
    localparam int               FLAT        = NCH * WIDTH;

    logic                 in_clk;
    logic                 in_rst;
    logic                 out_clk;
    logic                 out_rst;
    logic [NCH-1:0]       in_inc;
    logic [NCH-1:0]       in_dec;
    logic [FLAT-1:0]      in_counter;
    logic [FLAT-1:0]      out_counter;
    logic [WIDTH-1:0]     out_thresh;
    logic [NCH-1:0]       out_thresh_hit;
    logic                 out_snap_req;
    logic                 out_snap_valid;
    logic [FLAT-1:0]      out_snap;

    int                   tests_run;
    int                   tests_failed;
    logic [WIDTH-1:0]     model [NCH];
    logic [WIDTH-1:0]     exp_q [$];
    logic [FLAT-1:0]      snap_exp_q [$];
    logic [FLAT-1:0]      snap_last;

    logic                 mon_en;
    logic [WIDTH-GRAY_BITS-1:0] ext_prev;
    logic [WIDTH-GRAY_BITS-1:0] ext_now;
    int                   ext_up;
    int                   ext_down;
    logic                 found;

    cc_counter_mc #(
        .NCH         (NCH),
        .WIDTH       (WIDTH),
        .GRAY_BITS   (GRAY_BITS),
        .SYNC_STAGES (SYNC_STAGES),
        .UPDOWN      (UPDOWN),
        .INIT        (INIT)
    ) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .out_clk        (out_clk),
        .out_rst        (out_rst),
        .in_inc         (in_inc),
        .in_dec         (in_dec),
        .in_counter     (in_counter),
        .out_counter    (out_counter),
        .out_thresh     (out_thresh),
        .out_thresh_hit (out_thresh_hit),
        .out_snap_req   (out_snap_req),
        .out_snap_valid (out_snap_valid),
        .out_snap       (out_snap)
    );

    // 100 MHz source clock.
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    // ~33 MHz destination clock, phase-shifted off the source edges.
    initial begin
        out_clk = 1'b0;
        #3;
        forever #15 out_clk = ~out_clk;
    end

    // Count wraps of channel 0's upper bits as seen in the destination domain.
    always @(negedge out_clk) begin
        ext_now = out_counter[WIDTH-1:GRAY_BITS];
        if (mon_en && ext_now != ext_prev) begin
            if (ext_now == ext_prev + 1'b1) begin
                ext_up = ext_up + 1;
            end else if (ext_now == ext_prev - 1'b1) begin
                ext_down = ext_down + 1;
            end
        end
        ext_prev = ext_now;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WIDTH-1:0] chan(input logic [FLAT-1:0] v, input int c);
        return v[c*WIDTH +: WIDTH];
    endfunction

    task automatic check_output(input string tag, input logic [FLAT-1:0] obs,
                                input logic [FLAT-1:0] want);
        tests_run = tests_run + 1;
        assert (obs === want) else begin
            tests_failed = tests_failed + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Drive inc/dec masks for n source cycles and advance the model to match.
    task automatic apply_stimulus(input logic [NCH-1:0] inc, input logic [NCH-1:0] dec,
                                  input int n);
        for (int c = 0; c < NCH; c++) begin
            if (inc[c] && !dec[c]) begin
                model[c] = model[c] + WIDTH'(n);
            end else if (dec[c] && !inc[c]) begin
                model[c] = model[c] - WIDTH'(n);
            end
        end
        in_inc = inc;
        in_dec = dec;
        repeat (n) @(posedge in_clk);
        #1;
        in_inc = '0;
        in_dec = '0;
    endtask

    task automatic push_expected();
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back(model[c]);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [WIDTH-1:0] want;
        for (int c = 0; c < NCH; c++) begin
            want = exp_q.pop_front();
            check_output($sformatf("%s_out_ch%0d", tag, c),
                         FLAT'(chan(out_counter, c)), FLAT'(want));
        end
    endtask

    task automatic check_in(input string tag);
        for (int c = 0; c < NCH; c++) begin
            check_output($sformatf("%s_in_ch%0d", tag, c),
                         FLAT'(chan(in_counter, c)), FLAT'(model[c]));
        end
    endtask

    task automatic settle();
        repeat (12) @(posedge out_clk);
        @(negedge out_clk);
    endtask

    task automatic align_in();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        in_inc       = '0;
        in_dec       = '0;
        in_rst       = 1'b1;
        out_rst      = 1'b1;
        out_thresh   = 16'd10;
        out_snap_req = 1'b0;
        mon_en       = 1'b0;
        ext_up       = 0;
        ext_down     = 0;
        ext_prev     = '0;
        found        = 1'b0;
        snap_last    = '0;
        for (int c = 0; c < NCH; c++) begin
            model[c] = INIT;
        end

        // Reset state of both domains.
        repeat (4) @(posedge in_clk);
        #1;
        check_in("reset");
        check_output("reset_out_counter", out_counter, {NCH{INIT}});
        check_output("reset_out_snap", out_snap, {NCH{INIT}});
        check_output("reset_snap_valid", FLAT'(out_snap_valid), FLAT'(1'b0));
        check_output("reset_thresh_hit", FLAT'(out_thresh_hit), FLAT'(4'h0));
        in_rst = 1'b0;
        @(negedge out_clk);
        out_rst = 1'b0;

        // 1000 increments on channel 2 only.
        align_in();
        apply_stimulus(4'b0100, 4'b0000, 1000);
        push_expected();
        settle();
        compare_out("ch2_1000");
        check_in("ch2_1000");

        // Channel 0: 40 up then 50 down, crossing the Gray wrap both ways.
        align_in();
        ext_up   = 0;
        ext_down = 0;
        mon_en   = 1'b1;
        apply_stimulus(4'b0001, 4'b0000, 40);
        apply_stimulus(4'b0000, 4'b0001, 50);
        push_expected();
        settle();
        mon_en = 1'b0;
        compare_out("updown");
        check_in("updown");
        check_output("ch0_fff6", FLAT'(chan(out_counter, 0)), FLAT'(16'hFFF6));
        check_output("ext_up_cross", FLAT'(ext_up), FLAT'(2));
        check_output("ext_down_cross", FLAT'(ext_down), FLAT'(3));

        // Simultaneous inc and dec hold every channel.
        align_in();
        apply_stimulus(4'b1111, 4'b1111, 100);
        push_expected();
        check_in("both_hold");
        settle();
        compare_out("both_hold");

        // Threshold flag trails the count reaching 10 by one out_clk.
        align_in();
        apply_stimulus(4'b0010, 4'b0000, 9);
        settle();
        check_output("thresh_below", FLAT'(out_thresh_hit[1]), FLAT'(1'b0));
        align_in();
        apply_stimulus(4'b0010, 4'b0000, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge out_clk);
            if (chan(out_counter, 1) == 16'd10) begin
                found = 1'b1;
                check_output("thresh_same_cycle", FLAT'(out_thresh_hit[1]), FLAT'(1'b0));
                @(negedge out_clk);
                check_output("thresh_next_cycle", FLAT'(out_thresh_hit[1]), FLAT'(1'b1));
            end
        end
        check_output("thresh_seen", FLAT'(found), FLAT'(1'b1));
        push_expected();
        settle();
        compare_out("thresh");

        // Snapshots (single and back-to-back) while every channel counts.
        align_in();
        fork
            apply_stimulus(4'b1111, 4'b0000, 60);
            begin
                repeat (3) @(negedge out_clk);
                out_snap_req = 1'b1;
                snap_exp_q.push_back(out_counter);
                @(negedge out_clk);
                out_snap_req = 1'b0;
                check_output("snap1_valid", FLAT'(out_snap_valid), FLAT'(1'b1));
                check_output("snap1_data", out_snap, snap_exp_q.pop_front());
                @(negedge out_clk);
                check_output("snap1_valid_low", FLAT'(out_snap_valid), FLAT'(1'b0));
                out_snap_req = 1'b1;
                snap_exp_q.push_back(out_counter);
                @(negedge out_clk);
                snap_last = out_counter;
                snap_exp_q.push_back(snap_last);
                check_output("snap2_valid", FLAT'(out_snap_valid), FLAT'(1'b1));
                check_output("snap2_data", out_snap, snap_exp_q.pop_front());
                @(negedge out_clk);
                out_snap_req = 1'b0;
                check_output("snap3_valid", FLAT'(out_snap_valid), FLAT'(1'b1));
                check_output("snap3_data", out_snap, snap_exp_q.pop_front());
                @(negedge out_clk);
                check_output("snap3_valid_low", FLAT'(out_snap_valid), FLAT'(1'b0));
                check_output("snap3_hold", out_snap, snap_last);
            end
        join
        push_expected();
        settle();
        compare_out("snap_count");

        // Asynchronous destination reset in the middle of counting.
        align_in();
        fork
            apply_stimulus(4'b1111, 4'b0000, 90);
            begin
                repeat (5) @(posedge out_clk);
                #5;
                out_rst = 1'b1;
                #2;
                check_output("arst_out_counter", out_counter, {NCH{INIT}});
                check_output("arst_out_snap", out_snap, {NCH{INIT}});
                check_output("arst_snap_valid", FLAT'(out_snap_valid), FLAT'(1'b0));
                check_output("arst_thresh_hit", FLAT'(out_thresh_hit), FLAT'(4'h0));
            end
        join
        check_in("pre_in_rst");
        in_rst = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            model[c] = INIT;
        end
        check_in("in_rst");
        @(negedge out_clk);
        out_rst = 1'b0;
        align_in();
        apply_stimulus(4'b1111, 4'b0000, 50);
        push_expected();
        settle();
        compare_out("after_rst");
        check_in("after_rst");
        check_output("after_rst_hit", FLAT'(out_thresh_hit), FLAT'(4'hF));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
